matrix_mem_unit: RTL

- Memory and sequencing block that serves the pipelined MAC engine.
- Holds matrix A (row-major), matrix B (column-major) and result matrix C.
- Answers the MAC's read requests with fixed 1-cycle latency and captures its C write-backs.
- Host side loads A/B, issues a start command and reads C back after completion.

---
 rtl/matrix_mem_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/matrix_mem_unit.sv
// rtl/matrix_mem_unit.sv - A/B/C operand and result store with run sequencing for the MAC engine.
// Host loads A/B and reads C outside a run; the MAC reads A/B and writes C only while running.
module matrix_mem_unit #(
  parameter int param_M            = 4,
  parameter int param_K            = 4,
  parameter int param_N            = 4,
  parameter int DATA_WIDTH_INITIAL = 8,
  parameter int DATA_WIDTH_FINAL   = DATA_WIDTH_INITIAL * 2,
  parameter int HADDR_W            = $clog2(
    ((param_M*param_K > param_K*param_N) ? param_M*param_K : param_K*param_N) > param_M*param_N ?
    ((param_M*param_K > param_K*param_N) ? param_M*param_K : param_K*param_N) : param_M*param_N)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [1:0]                            host_sel,
  input  logic                                  host_we,
  input  logic                                  host_re,
  input  logic [HADDR_W-1:0]                    host_addr,
  input  logic [DATA_WIDTH_FINAL-1:0]           host_wdata,
  output logic [DATA_WIDTH_FINAL-1:0]           host_rdata,
  output logic                                  host_rvalid,
  input  logic                                  start,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic                                  mac_start,
  input  logic                                  a_b_re,
  input  logic [$clog2(param_M*param_K)-1:0]    a_addr_in,
  input  logic [$clog2(param_K*param_N)-1:0]    b_addr_in,
  output logic [DATA_WIDTH_INITIAL-1:0]         a_data_out,
  output logic [DATA_WIDTH_INITIAL-1:0]         b_data_out,
  input  logic                                  c_we,
  input  logic [$clog2(param_M*param_N)-1:0]    c_addr_in,
  input  logic [DATA_WIDTH_FINAL-1:0]           c_data_in,
  input  logic                                  mac_done
);

  localparam int MK   = param_M * param_K;
  localparam int KN   = param_K * param_N;
  localparam int MN   = param_M * param_N;
  localparam int AW_A = $clog2(MK);
  localparam int AW_B = $clog2(KN);
  localparam int AW_C = $clog2(MN);
  localparam int CW   = $clog2(MN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e state;
  logic [CW-1:0] wr_cnt;

  logic [DATA_WIDTH_INITIAL-1:0] mem_a [MK];
  logic [DATA_WIDTH_INITIAL-1:0] mem_b [KN];
  logic [DATA_WIDTH_FINAL-1:0]   mem_c [MN];

  logic            a_ok, b_ok, c_ok;
  logic            ha_ok, hb_ok, hc_ok;
  logic [AW_A-1:0] ha_idx;
  logic [AW_B-1:0] hb_idx;
  logic [AW_C-1:0] hc_idx;
  logic [DATA_WIDTH_FINAL-1:0] host_rd_val;

  assign a_ok   = 32'(a_addr_in) < MK;
  assign b_ok   = 32'(b_addr_in) < KN;
  assign c_ok   = 32'(c_addr_in) < MN;
  assign ha_ok  = 32'(host_addr) < MK;
  assign hb_ok  = 32'(host_addr) < KN;
  assign hc_ok  = 32'(host_addr) < MN;
  assign ha_idx = host_addr[AW_A-1:0];
  assign hb_idx = host_addr[AW_B-1:0];
  assign hc_idx = host_addr[AW_C-1:0];

  // Reserved select and out-of-range addresses read back as zero.
  always_comb begin
    host_rd_val = '0;
    case (host_sel)
      2'b00:   if (ha_ok) host_rd_val = DATA_WIDTH_FINAL'(mem_a[ha_idx]);
      2'b01:   if (hb_ok) host_rd_val = DATA_WIDTH_FINAL'(mem_b[hb_idx]);
      2'b10:   if (hc_ok) host_rd_val = mem_c[hc_idx];
      default: host_rd_val = '0;
    endcase
  end

  // Storage is never cleared; ownership switches between MAC (RUN) and host (otherwise).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RUN) begin
        if (c_we && c_ok) mem_c[c_addr_in] <= c_data_in;
      end else if (host_we) begin
        case (host_sel)
          2'b00:   if (ha_ok) mem_a[ha_idx] <= host_wdata[DATA_WIDTH_INITIAL-1:0];
          2'b01:   if (hb_ok) mem_b[hb_idx] <= host_wdata[DATA_WIDTH_INITIAL-1:0];
          2'b10:   if (hc_ok) mem_c[hc_idx] <= host_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mac_start   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      a_data_out  <= '0;
      b_data_out  <= '0;
      wr_cnt      <= '0;
    end else begin
      host_rvalid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_cnt    <= '0;
            mac_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (c_we && wr_cnt != CW'(MN)) wr_cnt <= wr_cnt + 1'b1;
          if (a_b_re) begin
            a_data_out <= a_ok ? mem_a[a_addr_in] : '0;
            b_data_out <= b_ok ? mem_b[b_addr_in] : '0;
          end
          // A write on the completing edge still counts toward the total.
          if (mac_done) begin
            state     <= DONE;
            mac_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            err       <= (32'(wr_cnt) + 32'(c_we)) != MN;
          end
        end
        default: state <= IDLE;
      endcase
      if (state != RUN && host_re) begin
        host_rvalid <= 1'b1;
        host_rdata  <= host_rd_val;
      end
    end
  end

endmodule
